// File: rtl/instr_fetch_queue_if.sv
// Bundle of the fetch front end's handshakes: redirect input, imem request/response, decode side.
// The master modport is the fetch queue itself; slave is the surrounding pipeline and memory.
interface instr_fetch_queue_if;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        err;

    modport master (
        input  redirect, redirect_pc, imem_req_ready, imem_rsp_valid, imem_rsp_data, instr_ready,
        output imem_req_valid, imem_req_addr, instr_valid, instr, instr_pc, err
    );

    modport slave (
        output redirect, redirect_pc, imem_req_ready, imem_rsp_valid, imem_rsp_data, instr_ready,
        input  imem_req_valid, imem_req_addr, instr_valid, instr, instr_pc, err
    );
endinterface

// File: rtl/instr_fetch_queue.sv
// Fetch front end: issues in-order imem reads under a credit limit, buffers returned words with
// their PC in a DEPTH-entry FIFO for decode, and flushes/discards in-flight work on redirect.
module instr_fetch_queue #(
    parameter int unsigned DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    instr_fetch_queue_if.master bus
);
    localparam int unsigned CW = $clog2(DEPTH + 1);
    localparam int unsigned PW = $clog2(DEPTH);

    typedef logic [CW-1:0] cnt_t;
    typedef logic [CW:0]   sum_t;
    typedef logic [PW-1:0] ptr_t;

    logic [31:0] fetch_pc_q, fetch_pc_d;
    logic [31:0] rsp_pc_q, rsp_pc_d;
    cnt_t        count_q, count_d;
    cnt_t        outstanding_q, outstanding_d;
    cnt_t        drop_cnt_q, drop_cnt_d;
    logic        err_q, err_d;
    ptr_t        rd_ptr_q, rd_ptr_d;
    ptr_t        wr_ptr_q, wr_ptr_d;

    logic [31:0] data_mem [DEPTH];
    logic [31:0] pc_mem   [DEPTH];

    logic credit_ok;
    logic req_fire;
    logic rsp_fire;
    logic push;
    logic pop;
    logic head_valid;

    // Buffered plus outstanding words never exceed DEPTH, so the FIFO cannot overflow.
    assign credit_ok  = (sum_t'(count_q) + sum_t'(outstanding_q)) < sum_t'(DEPTH);
    assign head_valid = (count_q != '0);

    assign bus.imem_req_valid = rst_ni & ~bus.redirect & credit_ok;
    assign bus.imem_req_addr  = fetch_pc_q;
    assign bus.instr_valid    = head_valid;
    assign bus.instr          = head_valid ? data_mem[rd_ptr_q] : '0;
    assign bus.instr_pc       = head_valid ? pc_mem[rd_ptr_q]   : '0;
    assign bus.err            = err_q;

    assign req_fire = bus.imem_req_valid & bus.imem_req_ready;
    assign rsp_fire = bus.imem_rsp_valid & (outstanding_q != '0);
    assign push     = rsp_fire & (drop_cnt_q == '0) & ~bus.redirect;
    assign pop      = head_valid & bus.instr_ready & ~bus.redirect;

    always_comb begin
        fetch_pc_d    = fetch_pc_q;
        rsp_pc_d      = rsp_pc_q;
        count_d       = count_q;
        drop_cnt_d    = drop_cnt_q;
        rd_ptr_d      = rd_ptr_q;
        wr_ptr_d      = wr_ptr_q;
        err_d         = err_q | (bus.imem_rsp_valid & (outstanding_q == '0));
        outstanding_d = outstanding_q + cnt_t'(req_fire) - cnt_t'(rsp_fire);

        if (bus.redirect) begin
            fetch_pc_d = bus.redirect_pc;
            rsp_pc_d   = bus.redirect_pc;
            count_d    = '0;
            rd_ptr_d   = '0;
            wr_ptr_d   = '0;
            // outstanding already includes words still awaiting a drop, so every
            // remaining in-flight response becomes stale.
            drop_cnt_d = outstanding_q - cnt_t'(rsp_fire);
        end else begin
            if (req_fire) begin
                fetch_pc_d = fetch_pc_q + 32'd4;
            end
            if (rsp_fire && (drop_cnt_q != '0)) begin
                drop_cnt_d = drop_cnt_q - cnt_t'(1);
            end
            if (push) begin
                rsp_pc_d = rsp_pc_q + 32'd4;
                wr_ptr_d = wr_ptr_q + ptr_t'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + ptr_t'(1);
            end
            count_d = count_q + cnt_t'(push) - cnt_t'(pop);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            fetch_pc_q    <= RESET_PC;
            rsp_pc_q      <= RESET_PC;
            count_q       <= '0;
            outstanding_q <= '0;
            drop_cnt_q    <= '0;
            err_q         <= 1'b0;
            rd_ptr_q      <= '0;
            wr_ptr_q      <= '0;
        end else begin
            fetch_pc_q    <= fetch_pc_d;
            rsp_pc_q      <= rsp_pc_d;
            count_q       <= count_d;
            outstanding_q <= outstanding_d;
            drop_cnt_q    <= drop_cnt_d;
            err_q         <= err_d;
            rd_ptr_q      <= rd_ptr_d;
            wr_ptr_q      <= wr_ptr_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (push) begin
            data_mem[wr_ptr_q] <= bus.imem_rsp_data;
            pc_mem[wr_ptr_q]   <= rsp_pc_q;
        end
    end
endmodule

// File: tb/tb_instr_fetch_queue.sv
// Directed bench for instr_fetch_queue: a latency-programmable memory model feeds the DUT, and a
// scoreboard monitor compares every decode handoff against hand-listed expected PCs.
module tb_instr_fetch_queue;
    localparam int unsigned DEPTH  = 4;
    localparam logic [31:0] RST_PC = 32'h0000_0040;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] data;
    } exp_t;

    typedef struct {
        int unsigned due;
        logic [31:0] addr;
    } pend_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    instr_fetch_queue_if bus ();

    instr_fetch_queue #(
        .DEPTH    (DEPTH),
        .RESET_PC (RST_PC)
    ) dut (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .bus    (bus)
    );

    exp_t  exp_q[$];
    pend_t pend[$];

    int errors = 0;
    int checks = 0;

    logic        nx_rst   = 1'b0;
    logic        nx_redir = 1'b0;
    logic        nx_irdy  = 1'b0;
    logic        nx_mrdy  = 1'b0;
    logic        nx_spur  = 1'b0;
    logic [31:0] nx_rpc   = '0;
    int unsigned lat      = 1;
    int unsigned cyc      = 0;
    int unsigned req_cnt  = 0;
    int unsigned c0       = 0;

    function automatic logic [31:0] data_of(input logic [31:0] a);
        return a ^ 32'hC0DE_0000;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, req);
        end
    endtask

    task automatic expect_pc(input logic [31:0] pc);
        exp_q.push_back('{pc, data_of(pc)});
    endtask

    // One clock: drive inputs at the falling edge, then model what memory accepts at the next rise.
    task automatic step();
        @(negedge clk);
        cyc++;
        rst_n              = nx_rst;
        bus.redirect       = nx_redir;
        bus.redirect_pc    = nx_rpc;
        bus.instr_ready    = nx_irdy;
        bus.imem_req_ready = nx_mrdy;
        bus.imem_rsp_valid = 1'b0;
        bus.imem_rsp_data  = '0;
        if (nx_spur) begin
            bus.imem_rsp_valid = 1'b1;
            bus.imem_rsp_data  = 32'hBADB_AD00;
        end else if (pend.size() != 0 && pend[0].due == cyc) begin
            bus.imem_rsp_valid = 1'b1;
            bus.imem_rsp_data  = data_of(pend[0].addr);
            void'(pend.pop_front());
        end
        #1;
        if (rst_n && bus.imem_req_valid && bus.imem_req_ready) begin
            pend.push_back('{cyc + lat, bus.imem_req_addr});
            req_cnt++;
        end
    endtask

    task automatic drain(input string name);
        int unsigned n = 0;
        while (exp_q.size() != 0 && n < 40) begin
            step();
            #2;
            n++;
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL %s_drain: %0d entries left, expected 0", name, exp_q.size());
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        #2;
        if (rst_n && bus.instr_valid && bus.instr_ready && !bus.redirect) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_pop: got pc %h, expected none", bus.instr_pc);
            end else begin
                e = exp_q.pop_front();
                check("instr_pc", bus.instr_pc, e.pc);
                check("instr", bus.instr, e.data);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bus.redirect       = 1'b0;
        bus.redirect_pc    = '0;
        bus.instr_ready    = 1'b0;
        bus.imem_req_ready = 1'b0;
        bus.imem_rsp_valid = 1'b0;
        bus.imem_rsp_data  = '0;

        repeat (3) step();
        check("reset_instr_valid", bus.instr_valid, 1'b0);
        check("reset_req_valid", bus.imem_req_valid, 1'b0);
        check("reset_err", bus.err, 1'b0);

        // Streaming with 1-cycle memory: one instruction per cycle after 2 cycles of latency
        lat     = 1;
        nx_irdy = 1'b1;
        nx_mrdy = 1'b1;
        nx_rst  = 1'b1;
        for (int i = 0; i < 8; i++) expect_pc(RST_PC + 32'(4 * i));
        step();
        c0 = cyc;
        check("t1_first_req_valid", bus.imem_req_valid, 1'b1);
        check("t1_first_req_addr", bus.imem_req_addr, RST_PC);
        drain("t1");
        check("t1_cycles", cyc - c0, 9);

        // Decode stalls: FIFO fills, then reset lands mid-cycle
        nx_irdy = 1'b0;
        repeat (6) step();
        check("t5_full_instr_valid", bus.instr_valid, 1'b1);
        check("t5_full_req_valid", bus.imem_req_valid, 1'b0);
        check("t5_full_count", 32'(dut.count_q), 4);
        #2;
        rst_n  = 1'b0;
        nx_rst = 1'b0;
        pend.delete();
        #1;
        check("t5_rst_instr_valid", bus.instr_valid, 1'b0);
        check("t5_rst_req_valid", bus.imem_req_valid, 1'b0);
        repeat (2) step();

        // Credit limit: exactly DEPTH requests with decode stalled
        nx_irdy = 1'b0;
        nx_mrdy = 1'b1;
        nx_rst  = 1'b1;
        req_cnt = 0;
        step();
        check("t5_release_req_valid", bus.imem_req_valid, 1'b1);
        check("t5_release_addr", bus.imem_req_addr, RST_PC);
        check("t2_idle_instr", bus.instr, 32'h0);
        check("t2_idle_instr_pc", bus.instr_pc, 32'h0);
        repeat (7) step();
        check("t2_req_count", req_cnt, 4);
        check("t2_req_valid_off", bus.imem_req_valid, 1'b0);
        nx_mrdy = 1'b0;
        nx_irdy = 1'b1;
        for (int i = 0; i < 4; i++) expect_pc(RST_PC + 32'(4 * i));
        drain("t2");

        // Redirect with two 3-cycle-latency reads in flight: both must be discarded
        lat     = 3;
        nx_mrdy = 1'b1;
        repeat (2) step();
        nx_mrdy  = 1'b0;
        nx_redir = 1'b1;
        nx_rpc   = 32'h0000_0100;
        step();
        nx_redir = 1'b0;
        nx_mrdy  = 1'b1;
        expect_pc(32'h0000_0100);
        expect_pc(32'h0000_0104);
        step();
        check("t3_drop_cnt", 32'(dut.drop_cnt_q), 2);
        step();
        nx_mrdy = 1'b0;
        drain("t3");
        repeat (3) step();

        // Redirect coinciding with a response and a pop, two reads outstanding
        lat     = 2;
        nx_mrdy = 1'b1;
        repeat (3) step();
        nx_mrdy  = 1'b0;
        nx_redir = 1'b1;
        nx_rpc   = 32'h0000_0200;
        step();
        check("t4_pre_instr_valid", bus.instr_valid, 1'b1);
        check("t4_pre_rsp_valid", bus.imem_rsp_valid, 1'b1);
        check("t4_pre_outstanding", 32'(dut.outstanding_q), 2);
        nx_redir = 1'b0;
        nx_mrdy  = 1'b1;
        expect_pc(32'h0000_0200);
        step();
        check("t4_count", 32'(dut.count_q), 0);
        check("t4_drop_cnt", 32'(dut.drop_cnt_q), 1);
        check("t4_outstanding", 32'(dut.outstanding_q), 1);
        check("t4_instr_valid", bus.instr_valid, 1'b0);
        nx_mrdy = 1'b0;
        drain("t4");
        repeat (3) step();

        // Spurious response with nothing outstanding
        lat     = 1;
        nx_irdy = 1'b0;
        nx_mrdy = 1'b1;
        step();
        nx_mrdy = 1'b0;
        step();
        check("t6_err_before", bus.err, 1'b0);
        nx_spur = 1'b1;
        step();
        nx_spur = 1'b0;
        step();
        check("t6_err_set", bus.err, 1'b1);
        check("t6_count", 32'(dut.count_q), 1);
        check("t6_rsp_pc", dut.rsp_pc_q, 32'h0000_0208);
        check("t6_outstanding", 32'(dut.outstanding_q), 0);
        repeat (3) step();
        check("t6_err_sticky", bus.err, 1'b1);
        expect_pc(32'h0000_0204);
        nx_irdy = 1'b1;
        drain("t6");
        repeat (3) step();
        check("t6_err_final", bus.err, 1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
